max7219_page_arbiter: RTL

Shares the single MAX7219 eight-digit display between up to NREQ requesters, for example the CPU status register, a debug PC and bus-error capture. It rotates the granted page round-robin on a dwell timer and honours per-requester lock. It produces the `clkdiv` enable strobe and the 32-bit `data_vector` that the MAX7219 serial driver consumes. Each value it presents is held stable for a full strobe period, so the driver never samples a changing word within one tick.

---
 rtl/max7219_ctrl_pkg.sv | 17 +
 rtl/tick_gen.sv | 38 +++
 rtl/max7219_page_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/max7219_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | max7219_ctrl_pkg: shared types for the MAX7219 display controller  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package max7219_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  localparam logic [31:0] BLANK_DEFAULT = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_gen: free-running divider with a registered one-cycle strobe  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tick_gen #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Strobe is registered from the next count so it lines up with cnt == DIV-1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick_o = tick_q;

endmodule
`default_nettype wire

// File: rtl/max7219_page_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | max7219_page_arbiter: round-robin page owner for one MAX7219 panel |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module max7219_page_arbiter
  import max7219_ctrl_pkg::*;
#(
  parameter int          NREQ  = 4,
  parameter int          DIV   = 8,
  parameter int          DWELL = 65536,
  parameter logic [31:0] BLANK = BLANK_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ-1:0]          req_lock_i,
  input  logic [NREQ*32-1:0]       req_data_i,
  output logic [NREQ-1:0]          grant_o,
  output logic [$clog2(NREQ)-1:0]  page_idx_o,
  output logic [31:0]              data_vector_o,
  output logic                     clkdiv_o
);

  localparam int            IW         = $clog2(NREQ);
  localparam int            DW         = $clog2(DWELL) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  // Returns {found, index} of the first valid requester scanning from start.
  function automatic logic [IW:0] rr_search(input logic [NREQ-1:0] valid, input int start);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = start + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (valid[IW'(idx)]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   page_q, page_d;
  logic [31:0]     data_q, data_d;
  logic [DW-1:0]   dwell_q, dwell_d;

  logic            w_tick;
  logic [31:0]     w_pages [NREQ];
  logic [IW:0]     w_rr;
  logic            w_found;
  logic [IW-1:0]   w_idx;
  int              w_start;
  logic            do_grant, go_idle;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_o  (w_tick)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_pages[gi] = req_data_i[32*gi +: 32];
  end

  // Every search (idle pickup, rotation, owner drop) starts at page_idx+1.
  always_comb begin
    w_start = (int'(page_q) + 1 >= NREQ) ? 0 : int'(page_q) + 1;
    w_rr    = rr_search(req_valid_i, w_start);
    w_found = w_rr[IW];
    w_idx   = w_rr[IW-1:0];
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    page_d   = page_q;
    data_d   = data_q;
    dwell_d  = dwell_q;
    do_grant = 1'b0;
    go_idle  = 1'b0;

    if (w_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (w_found) do_grant = 1'b1;
          else         data_d   = BLANK;
        end
        ST_SHOW, ST_LOCKED: begin
          if (!req_valid_i[page_q]) begin
            if (w_found) do_grant = 1'b1;
            else         go_idle  = 1'b1;
          end else if (state_q == ST_SHOW) begin
            if (req_lock_i[page_q]) begin
              state_d = ST_LOCKED;
              data_d  = w_pages[page_q];
            end else if (dwell_q == DWELL_LAST) begin
              do_grant = 1'b1;
            end else begin
              data_d  = w_pages[page_q];
              dwell_d = dwell_q + DW'(1);
            end
          end else begin
            if (!req_lock_i[page_q]) begin
              state_d = ST_SHOW;
            end else begin
              data_d = w_pages[page_q];
              if (dwell_q != DWELL_LAST) dwell_d = dwell_q + DW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (do_grant) begin
      state_d = ST_SHOW;
      grant_d = NREQ'(1) << w_idx;
      page_d  = w_idx;
      data_d  = w_pages[w_idx];
      dwell_d = '0;
    end
    if (go_idle) begin
      state_d = ST_IDLE;
      grant_d = '0;
      data_d  = BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      page_q  <= '0;
      data_q  <= BLANK;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      page_q  <= page_d;
      data_q  <= data_d;
      dwell_q <= dwell_d;
    end
  end

  assign grant_o       = grant_q;
  assign page_idx_o    = page_q;
  assign data_vector_o = data_q;
  assign clkdiv_o      = w_tick;

endmodule
`default_nettype wire
